// File: rtl/rf_pkg.sv
// Shared types and sizing for the RISC core register file.
package rf_pkg;

    localparam int DATA_W = 32;
    localparam int NREGS  = 32;
    localparam int AW     = $clog2(NREGS);

    typedef logic [DATA_W-1:0] reg_word_t;
    typedef logic [AW-1:0]     reg_addr_t;

    localparam reg_addr_t ZERO_REG = '0;

endpackage

// File: rtl/dff_word.sv
// One register-file word: enabled D flops with asynchronous active-low clear.
module dff_word
    import rf_pkg::*;
(
    input  logic      clk,
    input  logic      reset,
    input  logic      en,
    input  reg_word_t d,
    output reg_word_t q
);

    // NOTE: these words are flops, not an SRAM, so they can and must take the async clear.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            q <= '0;
        end else if (en) begin
            // NOTE: sequential state uses non-blocking assignment so all flops update together.
            q <= d;
        end
    end

endmodule

// File: rtl/reg_file_2r1w.sv
// 32x32 register file: two combinational read ports with write bypass,
// one enabled write port, and a per-register busy scoreboard for pending loads.
module reg_file_2r1w
    import rf_pkg::*;
(
    input  logic      clk,
    input  logic      reset,
    input  reg_addr_t rd_addr_a,
    input  reg_addr_t rd_addr_b,
    output reg_word_t rd_data_a,
    output reg_word_t rd_data_b,
    output logic      rd_busy_a,
    output logic      rd_busy_b,
    input  logic      wr_en,
    input  reg_addr_t wr_addr,
    input  reg_word_t wr_data,
    input  logic      set_busy,
    input  reg_addr_t busy_addr
);

    reg_word_t        words [NREGS];
    logic [NREGS-1:0] busy;
    logic [NREGS-1:0] busy_nxt;
    logic             wr_live;
    logic             byp_a;
    logic             byp_b;

    assign words[0] = '0;

    genvar i;
    generate
        for (i = 1; i < NREGS; i++) begin : g_word
            dff_word u_word (
                .clk   (clk),
                .reset (reset),
                .en    (wr_en && (wr_addr == reg_addr_t'(i))),
                .d     (wr_data),
                .q     (words[i])
            );
        end
    endgenerate

    always_comb begin
        // NOTE: start from the current value so every path assigns busy_nxt and no latch is inferred.
        busy_nxt = busy;
        if (wr_en) begin
            busy_nxt[wr_addr] = 1'b0;
        end
        // Applied after the clear: a new load supersedes a completing write to the same register.
        if (set_busy) begin
            busy_nxt[busy_addr] = 1'b1;
        end
        busy_nxt[ZERO_REG] = 1'b0;
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            busy <= '0;
        end else begin
            busy <= busy_nxt;
        end
    end

    // Bypass is gated by reset so the read ports show 0 while the file is being cleared.
    assign wr_live = reset && wr_en && (wr_addr != ZERO_REG);
    assign byp_a   = wr_live && (wr_addr == rd_addr_a);
    assign byp_b   = wr_live && (wr_addr == rd_addr_b);

    assign rd_data_a = byp_a ? wr_data : words[rd_addr_a];
    assign rd_data_b = byp_b ? wr_data : words[rd_addr_b];
    assign rd_busy_a = busy[rd_addr_a] && !byp_a;
    assign rd_busy_b = busy[rd_addr_b] && !byp_b;

endmodule

// File: tb/tb_reg_file_2r1w.sv
// Directed bench for reg_file_2r1w: vector table plus reset sequences.
`timescale 1ns/100ps
module tb_reg_file_2r1w;
    import rf_pkg::*;

    typedef struct {
        logic      wr_en;
        reg_addr_t wr_addr;
        reg_word_t wr_data;
        logic      set_busy;
        reg_addr_t busy_addr;
        reg_addr_t ra;
        reg_addr_t rb;
        reg_word_t exp_a;
        reg_word_t exp_b;
        logic      exp_busy_a;
        logic      exp_busy_b;
    } vec_t;

    logic      clk = 1'b0;
    logic      reset = 1'b0;
    reg_addr_t rd_addr_a = '0;
    reg_addr_t rd_addr_b = '0;
    reg_word_t rd_data_a;
    reg_word_t rd_data_b;
    logic      rd_busy_a;
    logic      rd_busy_b;
    logic      wr_en = 1'b0;
    reg_addr_t wr_addr = '0;
    reg_word_t wr_data = '0;
    logic      set_busy = 1'b0;
    reg_addr_t busy_addr = '0;

    int checks = 0;
    int errors = 0;
    vec_t vecs[$];

    reg_file_2r1w dut (
        .clk       (clk),
        .reset     (reset),
        .rd_addr_a (rd_addr_a),
        .rd_addr_b (rd_addr_b),
        .rd_data_a (rd_data_a),
        .rd_data_b (rd_data_b),
        .rd_busy_a (rd_busy_a),
        .rd_busy_b (rd_busy_b),
        .wr_en     (wr_en),
        .wr_addr   (wr_addr),
        .wr_data   (wr_data),
        .set_busy  (set_busy),
        .busy_addr (busy_addr)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %08h expected %08h", name, act, exp);
        end
    endtask

    task automatic drive(input logic we, input reg_addr_t wa, input reg_word_t wd,
                         input logic sb, input reg_addr_t ba,
                         input reg_addr_t ra, input reg_addr_t rb);
        wr_en     = we;
        wr_addr   = wa;
        wr_data   = wd;
        set_busy  = sb;
        busy_addr = ba;
        rd_addr_a = ra;
        rd_addr_b = rb;
    endtask

    task automatic check_ports(input string tag, input reg_word_t ea, input reg_word_t eb,
                               input logic ba, input logic bb);
        check({tag, " data_a"}, rd_data_a, ea);
        check({tag, " data_b"}, rd_data_b, eb);
        check({tag, " busy_a"}, 32'(rd_busy_a), 32'(ba));
        check({tag, " busy_b"}, 32'(rd_busy_b), 32'(bb));
    endtask

    function automatic vec_t mk(logic we, int wa, logic [31:0] wd, logic sb, int ba,
                                int ra, int rb, logic [31:0] ea, logic [31:0] eb,
                                logic bsa, logic bsb);
        vec_t v;
        v.wr_en = we;      v.wr_addr = reg_addr_t'(wa); v.wr_data = wd;
        v.set_busy = sb;   v.busy_addr = reg_addr_t'(ba);
        v.ra = reg_addr_t'(ra); v.rb = reg_addr_t'(rb);
        v.exp_a = ea;      v.exp_b = eb;
        v.exp_busy_a = bsa; v.exp_busy_b = bsb;
        return v;
    endfunction

    initial begin
        // Each row is one cycle; expectations are the pre-edge combinational outputs.
        vecs.push_back(mk(1,  5, 32'hDEADBEEF, 0,  0,  5,  5, 32'hDEADBEEF, 32'hDEADBEEF, 0, 0));
        vecs.push_back(mk(0,  5, 32'h12345678, 0,  0,  5,  5, 32'hDEADBEEF, 32'hDEADBEEF, 0, 0));
        vecs.push_back(mk(1,  0, 32'hFFFFFFFF, 1,  0,  0,  5, 32'h0,        32'hDEADBEEF, 0, 0));
        vecs.push_back(mk(1,  8, 32'h0BAD0008, 0,  0,  0,  0, 32'h0,        32'h0,        0, 0));
        vecs.push_back(mk(1,  7, 32'hA5A5A5A5, 0,  0,  7,  8, 32'hA5A5A5A5, 32'h0BAD0008, 0, 0));
        vecs.push_back(mk(0,  0, 32'h0,        0,  0,  7,  8, 32'hA5A5A5A5, 32'h0BAD0008, 0, 0));
        vecs.push_back(mk(0,  0, 32'h0,        1,  3,  3,  3, 32'h0,        32'h0,        0, 0));
        vecs.push_back(mk(0,  0, 32'h0,        0,  0,  3,  7, 32'h0,        32'hA5A5A5A5, 1, 0));
        vecs.push_back(mk(1,  3, 32'h00000011, 0,  0,  3,  3, 32'h00000011, 32'h00000011, 0, 0));
        vecs.push_back(mk(0,  0, 32'h0,        0,  0,  3,  3, 32'h00000011, 32'h00000011, 0, 0));
        vecs.push_back(mk(1,  3, 32'h00000022, 1,  3,  3,  4, 32'h00000022, 32'h0,        0, 0));
        vecs.push_back(mk(0,  0, 32'h0,        0,  0,  3,  3, 32'h00000022, 32'h00000022, 1, 1));
        vecs.push_back(mk(1,  3, 32'h00000033, 1,  4,  3,  4, 32'h00000033, 32'h0,        0, 0));
        vecs.push_back(mk(0,  0, 32'h0,        0,  0,  3,  4, 32'h00000033, 32'h0,        0, 1));
        vecs.push_back(mk(1,  4, 32'h00000044, 0,  0,  4,  3, 32'h00000044, 32'h00000033, 0, 0));
        vecs.push_back(mk(0,  0, 32'h0,        1, 10,  4,  4, 32'h00000044, 32'h00000044, 0, 0));
        vecs.push_back(mk(0,  0, 32'h0,        0,  0, 10,  5, 32'h0,        32'hDEADBEEF, 1, 0));

        // Power-on reset, released between edges.
        repeat (2) @(negedge clk);
        #1;
        check_ports("por", 32'h0, 32'h0, 0, 0);
        @(negedge clk);
        reset = 1'b1;

        foreach (vecs[k]) begin
            @(negedge clk);
            drive(vecs[k].wr_en, vecs[k].wr_addr, vecs[k].wr_data,
                  vecs[k].set_busy, vecs[k].busy_addr, vecs[k].ra, vecs[k].rb);
            #1;
            check_ports($sformatf("vec%0d", k), vecs[k].exp_a, vecs[k].exp_b,
                        vecs[k].exp_busy_a, vecs[k].exp_busy_b);
        end

        // Async reset 4 ns after an edge while a write to r7 and a set_busy are pending.
        @(negedge clk);
        drive(1, 5'd7, 32'hFFFFFFFF, 1, 5'd12, 5'd7, 5'd10);
        @(posedge clk);
        #4;
        reset = 1'b0;
        #0.5;
        check_ports("rst immediate", 32'h0, 32'h0, 0, 0);
        for (int a = 0; a < NREGS; a++) begin
            @(negedge clk);
            rd_addr_a = reg_addr_t'(a);
            rd_addr_b = reg_addr_t'(NREGS - 1 - a);
            #1;
            check_ports($sformatf("rst sweep%0d", a), 32'h0, 32'h0, 0, 0);
        end
        @(negedge clk);
        drive(0, 5'd0, 32'h0, 0, 5'd0, 5'd7, 5'd12);
        reset = 1'b1;
        @(negedge clk);
        #1;
        check_ports("post rst r7/r12", 32'h0, 32'h0, 0, 0);

        // Reset mid-operation on r9: value and busy discarded, then writable again.
        @(negedge clk);
        drive(1, 5'd9, 32'h00000055, 1, 5'd9, 5'd9, 5'd9);
        @(negedge clk);
        drive(0, 5'd0, 32'h0, 0, 5'd0, 5'd9, 5'd9);
        #1;
        check_ports("r9 loaded", 32'h55, 32'h55, 1, 1);
        @(negedge clk);
        drive(1, 5'd9, 32'h00000077, 0, 5'd0, 5'd9, 5'd9);
        @(posedge clk);
        #4;
        reset = 1'b0;
        #0.5;
        check_ports("r9 in reset", 32'h0, 32'h0, 0, 0);
        @(negedge clk);
        drive(0, 5'd0, 32'h0, 0, 5'd0, 5'd9, 5'd9);
        reset = 1'b1;
        #1;
        check_ports("r9 cleared", 32'h0, 32'h0, 0, 0);
        @(negedge clk);
        drive(1, 5'd9, 32'h00000066, 0, 5'd0, 5'd1, 5'd2);
        @(negedge clk);
        drive(0, 5'd0, 32'h0, 0, 5'd0, 5'd9, 5'd9);
        #1;
        check_ports("r9 rewrite", 32'h66, 32'h66, 0, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
